// File: rtl/i2c_req_arbiter_pkg.sv
// Shared definitions for the I2C requester arbiter: FSM states, response codes
// and the default watchdog length.
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_NACK    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // 2 ms at 12 MHz
  localparam int TIMEOUT_CYC_DEFAULT = 24000;

endpackage

// File: rtl/i2c_req_arbiter_if.sv
// Start/done handshake and latched command between the arbiter (master side)
// and the shared I2C byte-transaction engine (slave side).
interface i2c_req_arbiter_if;

  logic       start;
  logic       rd;
  logic [6:0] dev_addr;
  logic [7:0] reg_addr;
  logic [7:0] wdata;
  logic       abort;
  logic       busy;
  logic       done;
  logic       nack;
  logic [7:0] rdata;

  modport master (
    output start, rd, dev_addr, reg_addr, wdata, abort,
    input  busy, done, nack, rdata
  );

  modport slave (
    input  start, rd, dev_addr, reg_addr, wdata, abort,
    output busy, done, nack, rdata
  );

endinterface

// File: rtl/i2c_req_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request bit at or after ptr,
// wrapping around. Usable by any shared-bus controller.
module rr_pick #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] idx,
  output logic          valid
);

  int          j;
  logic [PW-1:0] jj;

  // Scan from the farthest offset down so the nearest set bit is written last.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    jj    = '0;
    for (int off = N - 1; off >= 0; off--) begin
      j  = (int'(ptr) + off) % N;
      jj = PW'(j);
      if (req[jj]) begin
        idx   = jj;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one I2C transaction engine between N_REQ
// requesters; one transaction per grant, one response per transaction.
module i2c_req_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     req_rd,
  input  logic [7*N_REQ-1:0]   req_dev_addr,
  input  logic [8*N_REQ-1:0]   req_reg_addr,
  input  logic [8*N_REQ-1:0]   req_wdata,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [7:0]           rsp_rdata,
  output logic [1:0]           rsp_err,
  output logic                 busy,
  i2c_req_arbiter_if.master    eng
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT_CYC);

  arb_state_e        state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [7:0]        rsp_rdata_q, rsp_rdata_d;
  logic [1:0]        rsp_err_q, rsp_err_d;
  logic              busy_q, busy_d;
  logic              start_q, start_d;
  logic              abort_q, abort_d;
  logic              cmd_rd_q, cmd_rd_d;
  logic [6:0]        cmd_dev_q, cmd_dev_d;
  logic [7:0]        cmd_reg_q, cmd_reg_d;
  logic [7:0]        cmd_wdata_q, cmd_wdata_d;

  logic [PW-1:0]     pick_idx;
  logic              pick_valid;

  rr_pick #(.N(N_REQ)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Every output is the registered copy of a next-value computed below, so a
  // decision made in one state becomes visible in the following cycle.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    start_d     = 1'b0;
    abort_d     = 1'b0;
    cmd_rd_d    = cmd_rd_q;
    cmd_dev_d   = cmd_dev_q;
    cmd_reg_d   = cmd_reg_q;
    cmd_wdata_d = cmd_wdata_q;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          idx_d       = pick_idx;
          gnt_d       = N_REQ'(1) << pick_idx;
          cmd_rd_d    = req_rd[pick_idx];
          cmd_dev_d   = req_dev_addr[7*pick_idx +: 7];
          cmd_reg_d   = req_reg_addr[8*pick_idx +: 8];
          cmd_wdata_d = req_wdata[8*pick_idx +: 8];
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (!eng.busy) begin
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A done arriving on the final watchdog cycle still counts as success.
        if (eng.done) begin
          rsp_rdata_d = eng.rdata;
          rsp_err_d   = eng.nack ? ERR_NACK : ERR_OK;
          rsp_valid_d = gnt_q;
          state_d     = RESP;
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          abort_d     = 1'b1;
          rsp_rdata_d = 8'h00;
          rsp_err_d   = ERR_TIMEOUT;
          rsp_valid_d = gnt_q;
          state_d     = RESP;
        end
      end
      RESP: begin
        gnt_d       = '0;
        rsp_rdata_d = 8'h00;
        rsp_err_d   = ERR_OK;
        ptr_d       = (idx_q == PW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= ERR_OK;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
      abort_q     <= 1'b0;
      cmd_rd_q    <= 1'b0;
      cmd_dev_q   <= '0;
      cmd_reg_q   <= '0;
      cmd_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      start_q     <= start_d;
      abort_q     <= abort_d;
      cmd_rd_q    <= cmd_rd_d;
      cmd_dev_q   <= cmd_dev_d;
      cmd_reg_q   <= cmd_reg_d;
      cmd_wdata_q <= cmd_wdata_d;
    end
  end

  assign gnt          = gnt_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_err      = rsp_err_q;
  assign busy         = busy_q;
  assign eng.start    = start_q;
  assign eng.abort    = abort_q;
  assign eng.rd       = cmd_rd_q;
  assign eng.dev_addr = cmd_dev_q;
  assign eng.reg_addr = cmd_reg_q;
  assign eng.wdata    = cmd_wdata_q;

endmodule
